// File: rtl/filters_mul_arbiter_if.sv
// Handshake and result bus between the filter tap engines (master) and the
// shared multiplier arbiter (slave).
interface filters_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
);
    logic                         en;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*A_WIDTH-1:0]   req_a;
    logic [NUM_REQ*B_WIDTH-1:0]   req_b;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [P_WIDTH-1:0]           rsp_p;
    logic                         idle;

    modport master (
        output en, req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_p, idle
    );

    modport slave (
        input  en, req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_p, idle
    );
endinterface

// File: rtl/filters_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed x unsigned multiplier
// among NUM_REQ requesters. Each pipeline stage carries a valid bit and the
// requester index so the product comes back with a one-hot strobe.
module filters_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 16,
    parameter int P_WIDTH    = A_WIDTH + B_WIDTH,
    parameter int MUL_STAGES = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    filters_mul_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   gnt_idx;
    logic               grant;
    logic [A_WIDTH-1:0] sel_a;
    logic [B_WIDTH-1:0] sel_b;

    // Stage 0 holds the captured operands; stages 1..MUL_STAGES hold products.
    logic [MUL_STAGES:0] v_q;
    logic [IDX_W-1:0]    idx_q [MUL_STAGES+1];
    logic [A_WIDTH-1:0]  a_q;
    logic [B_WIDTH-1:0]  b_q;
    logic [P_WIDTH-1:0]  p_q   [MUL_STAGES];

    logic [P_WIDTH-1:0]  a_ext, b_ext, prod;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (bus.en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
                if (!grant && bus.req_valid[cand]) begin
                    grant   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        last_d = grant ? gnt_idx : last_q;
        sel_a  = bus.req_a[gnt_idx*A_WIDTH +: A_WIDTH];
        sel_b  = bus.req_b[gnt_idx*B_WIDTH +: B_WIDTH];
    end

    // Both operands widened to the full product width: sign-extend a,
    // zero-extend b, so the low P_WIDTH bits of the product are exact.
    always_comb begin
        a_ext = {{(P_WIDTH-A_WIDTH){a_q[A_WIDTH-1]}}, a_q};
        b_ext = {{(P_WIDTH-B_WIDTH){1'b0}}, b_q};
        prod  = a_ext * b_ext;
    end

    // Arbitration pointer and multiplier pipeline.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_q <= IDX_W'(NUM_REQ-1);
            v_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            for (int s = 0; s <= MUL_STAGES; s++) idx_q[s] <= '0;
            for (int s = 0; s < MUL_STAGES; s++)  p_q[s]   <= '0;
        end else begin
            last_q   <= last_d;
            v_q[0]   <= grant;
            idx_q[0] <= gnt_idx;
            if (grant) begin
                a_q <= sel_a;
                b_q <= sel_b;
            end
            v_q[1]   <= v_q[0];
            idx_q[1] <= idx_q[0];
            if (v_q[0]) p_q[0] <= prod;
            // Products only move with a valid bit so rsp_p holds between results.
            for (int s = 2; s <= MUL_STAGES; s++) begin
                v_q[s]   <= v_q[s-1];
                idx_q[s] <= idx_q[s-1];
                if (v_q[s-1]) p_q[s-1] <= p_q[s-2];
            end
        end
    end

    // Grant, response strobe and idle decode.
    always_comb begin
        bus.req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
        bus.rsp_valid = v_q[MUL_STAGES] ? (NUM_REQ'(1) << idx_q[MUL_STAGES]) : '0;
        bus.rsp_p     = p_q[MUL_STAGES-1];
        bus.idle      = ~(|v_q) & ~grant;
    end
endmodule

// File: tb/tb_filters_mul_arbiter.sv
module tb_filters_mul_arbiter;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int PW = 32;
    localparam int MS = 2;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    filters_mul_arbiter_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

    filters_mul_arbiter #(
        .NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_STAGES(MS)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc = cyc + 1;

    typedef struct {
        int     idx;
        longint p;
        int     due;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: round-robin pointer kept as a plain integer; every
    // accepted operation is pushed with its exact product and due cycle.
    int     last_m = NR - 1;
    logic [NR-1:0] exp_rdy;
    logic signed [AW-1:0] m_a;
    logic [BW-1:0] m_b;
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            exp_q.delete();
            last_m = NR - 1;
        end else begin
            exp_rdy = '0;
            if (bus.en) begin
                for (int k = 1; k <= NR; k++) begin
                    if (bus.req_valid[(last_m + k) % NR]) begin
                        exp_rdy[(last_m + k) % NR] = 1'b1;
                        break;
                    end
                end
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            for (int i = 0; i < NR; i++) begin
                if (exp_rdy[i]) begin
                    m_a = bus.req_a[i*AW +: AW];
                    m_b = bus.req_b[i*BW +: BW];
                    exp_q.push_back('{idx: i, p: longint'(m_a) * longint'(m_b), due: cyc + 1 + MS});
                    last_m = i;
                end
            end
        end
    end

    // Monitor: idle check, then pop and compare on every response strobe.
    exp_t e;
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            chk("idle", bus.idle, longint'(exp_q.size() == 0 && !(bus.en && (|bus.req_valid))));
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                chk("rsp_missing", cyc, e.due);
            end
            if (bus.rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", bus.rsp_valid, longint'(1) << e.idx);
                    chk("rsp_p", longint'($signed(bus.rsp_p)), e.p);
                    chk("rsp_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        bus.req_valid[i]   = 1'b1;
        bus.req_a[i*AW +: AW] = a;
        bus.req_b[i*BW +: BW] = b;
    endtask

    task automatic wait_accept(input int i);
        bit done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge ap_clk);
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                @(posedge ap_clk);
                #1;
                bus.req_valid[i] = 1'b0;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", i, -1);
    endtask

    task automatic run_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        set_req(i, a, b);
        wait_accept(i);
    endtask

    // One clock: note what was accepted, then drop those valids after the edge.
    task automatic step(output logic [NR-1:0] acc);
        @(negedge ap_clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge ap_clk);
        #1;
        bus.req_valid = bus.req_valid & ~acc;
    endtask

    function automatic logic [AW-1:0] rnd_a();
        case ($urandom_range(7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            default: return AW'($urandom);
        endcase
    endfunction

    function automatic logic [BW-1:0] rnd_b();
        case ($urandom_range(7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return BW'($urandom);
        endcase
    endfunction

    task automatic do_reset(input int cycles);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        repeat (cycles) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    logic [NR-1:0] acc;

    initial begin
        bus.en        = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        @(negedge ap_clk);
        chk("reset_ready", bus.req_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_p", bus.rsp_p, 0);
        chk("reset_idle", bus.idle, 1);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.en = 1'b1;

        // Single op and extremes.
        run_op(1, 16'hFFFD, 16'd7);
        repeat (5) @(posedge ap_clk);
        #1;
        run_op(0, 16'h8000, 16'hFFFF);
        run_op(2, 16'h7FFF, 16'hFFFF);
        run_op(3, 16'hFFFF, 16'h0000);
        repeat (4) @(posedge ap_clk);
        #1;

        // Fairness: after requester 2, simultaneous 0 and 3 go 3 then 0.
        run_op(2, 16'd100, 16'd5);
        set_req(0, 16'd11, 16'd12);
        set_req(3, 16'hFFF0, 16'd13);
        fork
            wait_accept(0);
            wait_accept(3);
        join
        repeat (4) @(posedge ap_clk);
        #1;

        // All four requesting continuously from reset.
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*AW +: AW] = rnd_a();
            bus.req_b[i*BW +: BW] = rnd_b();
        end
        do_reset(2);
        for (int n = 0; n < 16; n++) begin
            @(negedge ap_clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge ap_clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    bus.req_a[i*AW +: AW] = rnd_a();
                    bus.req_b[i*BW +: BW] = rnd_b();
                end
            end
        end
        bus.req_valid = '0;
        repeat (4) @(posedge ap_clk);
        #1;

        // en low with two ops in flight and requests pending.
        set_req(0, rnd_a(), rnd_b());
        set_req(1, rnd_a(), rnd_b());
        step(acc);
        step(acc);
        bus.en = 1'b0;
        set_req(2, rnd_a(), rnd_b());
        set_req(3, rnd_a(), rnd_b());
        repeat (5) step(acc);
        bus.en = 1'b1;
        for (int n = 0; n < 10 && bus.req_valid != '0; n++) step(acc);
        chk("en_resume_drained", bus.req_valid, 0);
        repeat (4) @(posedge ap_clk);
        #1;

        // Reset with two ops in flight, while the first result is on the bus.
        set_req(1, rnd_a(), rnd_b());
        set_req(2, rnd_a(), rnd_b());
        step(acc);
        step(acc);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_idle", bus.idle, 1);
        set_req(0, rnd_a(), rnd_b());
        set_req(3, rnd_a(), rnd_b());
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        fork
            wait_accept(0);
            wait_accept(3);
        join

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            @(negedge ap_clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge ap_clk);
            #1;
            bus.en = ($urandom_range(9) != 0);
            for (int i = 0; i < NR; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(2) != 0);
                    bus.req_a[i*AW +: AW] = rnd_a();
                    bus.req_b[i*BW +: BW] = rnd_b();
                end
            end
        end

        bus.en        = 1'b1;
        bus.req_valid = '0;
        repeat (10) @(negedge ap_clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
